// File: rtl/pe_ws_pkg.sv
// Shared types and default widths for the weight-stationary processing element.
package pe_ws_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ACC_W  = 32;

    typedef enum logic {
        PASSTHROUGH = 1'b0,
        PROCESS     = 1'b1
    } pe_mode_t;

endpackage : pe_ws_pkg

// File: rtl/pe_ws_if.sv
// Neighbour-facing signal bundle of one PE: activations, partial sums, weight chain, control and flags.
interface pe_ws_if
    import pe_ws_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
);

    logic [DATA_W-1:0] left_data_i;
    logic              left_valid_i;
    logic [DATA_W-1:0] right_data_o;
    logic              right_valid_o;
    logic [ACC_W-1:0]  top_psum_i;
    logic              top_valid_i;
    logic [ACC_W-1:0]  bottom_psum_o;
    logic              bottom_valid_o;
    logic [DATA_W-1:0] w_data_i;
    logic              w_load_i;
    logic [DATA_W-1:0] w_data_o;
    logic              w_load_o;
    logic              swap_i;
    logic              swap_o;
    pe_mode_t          mode_i;
    logic              add_zero_i;
    logic              clr_flags_i;
    logic              ovf_o;
    logic              err_o;

    // Array/controller side driving the PE
    modport master (
        output left_data_i, left_valid_i, top_psum_i, top_valid_i,
               w_data_i, w_load_i, swap_i, mode_i, add_zero_i, clr_flags_i,
        input  right_data_o, right_valid_o, bottom_psum_o, bottom_valid_o,
               w_data_o, w_load_o, swap_o, ovf_o, err_o
    );

    // PE side
    modport slave (
        input  left_data_i, left_valid_i, top_psum_i, top_valid_i,
               w_data_i, w_load_i, swap_i, mode_i, add_zero_i, clr_flags_i,
        output right_data_o, right_valid_o, bottom_psum_o, bottom_valid_o,
               w_data_o, w_load_o, swap_o, ovf_o, err_o
    );

endinterface : pe_ws_if

// File: rtl/pe_mac.sv
// Combinational multiply-add with optional clamping; the add runs one bit wider than the
// accumulator so overflow is detected exactly from the top two sum bits.
module pe_mac #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ACC_W    = 32,
    parameter bit          SIGNED   = 1'b1,
    parameter bit          SATURATE = 1'b1
) (
    input  logic [DATA_W-1:0] i_weight,
    input  logic [DATA_W-1:0] i_act,
    input  logic [ACC_W-1:0]  i_psum,
    input  logic              i_add_zero,
    output logic [ACC_W-1:0]  o_psum_c,
    output logic              o_ovf_c
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned EXT_W  = SUM_W - PROD_W;

    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_b_ext;
    logic [PROD_W-1:0] w_prod;
    logic [SUM_W-1:0]  w_prod_ext;
    logic [SUM_W-1:0]  w_psum_ext;
    logic [SUM_W-1:0]  w_sum;
    logic              w_ovf;

    // Operands extended to product width so the low PROD_W bits are exact in either signedness
    always_comb begin
        w_a_ext    = {{DATA_W{SIGNED & i_weight[DATA_W-1]}}, i_weight};
        w_b_ext    = {{DATA_W{SIGNED & i_act[DATA_W-1]}}, i_act};
        w_prod     = w_a_ext * w_b_ext;
        w_prod_ext = {{EXT_W{SIGNED & w_prod[PROD_W-1]}}, w_prod};
        w_psum_ext = i_add_zero ? '0 : {SIGNED & i_psum[ACC_W-1], i_psum};
        w_sum      = w_prod_ext + w_psum_ext;
        w_ovf      = SIGNED ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];
    end

    always_comb begin
        o_ovf_c  = w_ovf;
        o_psum_c = w_sum[ACC_W-1:0];
        if (SATURATE && w_ovf) begin
            if (!SIGNED) begin
                o_psum_c = '1;
            end else if (w_sum[ACC_W]) begin
                o_psum_c = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                o_psum_c = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end

endmodule : pe_mac

// File: rtl/pe_ws.sv
// Weight-stationary systolic PE: double-buffered weight with a column shift chain,
// activation forwarding to the right and a registered MAC result downward.
module pe_ws
    import pe_ws_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ACC_W    = DEF_ACC_W,
    parameter bit          SIGNED   = 1'b1,
    parameter bit          SATURATE = 1'b1
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    pe_ws_if.slave  bus
);

    logic [DATA_W-1:0] r_right_data;
    logic              r_right_valid;
    logic              r_w_load;
    logic              r_swap;
    logic [DATA_W-1:0] r_shadow_w;
    logic [DATA_W-1:0] r_active_w;
    logic [DATA_W-1:0] r_w_data;
    logic [ACC_W-1:0]  r_bottom_psum;
    logic              r_bottom_valid;
    logic              r_ovf;
    logic              r_err;

    logic [ACC_W-1:0]  w_mac_psum;
    logic              w_mac_ovf;
    logic [ACC_W-1:0]  w_psum_nxt;
    logic              w_valid_nxt;
    logic              w_ovf_set;
    logic              w_err_set;
    logic              w_ovf_nxt;
    logic              w_err_nxt;

    // The multiplier always sees the pre-swap active weight
    pe_mac #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_mac (
        .i_weight   (r_active_w),
        .i_act      (bus.left_data_i),
        .i_psum     (bus.top_psum_i),
        .i_add_zero (bus.add_zero_i),
        .o_psum_c   (w_mac_psum),
        .o_ovf_c    (w_mac_ovf)
    );

    always_comb begin
        w_psum_nxt  = r_bottom_psum;
        w_valid_nxt = 1'b0;
        w_ovf_set   = 1'b0;
        w_err_set   = 1'b0;
        if (bus.mode_i == PASSTHROUGH) begin
            w_psum_nxt  = bus.top_psum_i;
            w_valid_nxt = bus.top_valid_i;
        end else if (bus.left_valid_i) begin
            w_psum_nxt  = w_mac_psum;
            w_valid_nxt = 1'b1;
            w_ovf_set   = w_mac_ovf;
            w_err_set   = !bus.add_zero_i && !bus.top_valid_i;
        end
        // Clear wins over a same-cycle set
        w_ovf_nxt = bus.clr_flags_i ? 1'b0 : (r_ovf | w_ovf_set);
        w_err_nxt = bus.clr_flags_i ? 1'b0 : (r_err | w_err_set);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_right_data   <= '0;
            r_right_valid  <= 1'b0;
            r_w_load       <= 1'b0;
            r_swap         <= 1'b0;
            r_shadow_w     <= '0;
            r_active_w     <= '0;
            r_w_data       <= '0;
            r_bottom_psum  <= '0;
            r_bottom_valid <= 1'b0;
            r_ovf          <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_right_data   <= bus.left_data_i;
            r_right_valid  <= bus.left_valid_i;
            r_w_load       <= bus.w_load_i;
            r_swap         <= bus.swap_i;
            if (bus.w_load_i) begin
                r_shadow_w <= bus.w_data_i;
                r_w_data   <= r_shadow_w;
            end
            if (bus.swap_i) begin
                r_active_w <= r_shadow_w;
            end
            r_bottom_psum  <= w_psum_nxt;
            r_bottom_valid <= w_valid_nxt;
            r_ovf          <= w_ovf_nxt;
            r_err          <= w_err_nxt;
        end
    end

    assign bus.right_data_o   = r_right_data;
    assign bus.right_valid_o  = r_right_valid;
    assign bus.w_load_o       = r_w_load;
    assign bus.swap_o         = r_swap;
    assign bus.w_data_o       = r_w_data;
    assign bus.bottom_psum_o  = r_bottom_psum;
    assign bus.bottom_valid_o = r_bottom_valid;
    assign bus.ovf_o          = r_ovf;
    assign bus.err_o          = r_err;

endmodule : pe_ws

// File: tb/tb_pe_ws.sv
// Bench for pe_ws: a saturating and a wrapping instance share one stimulus stream and are
// compared against an integer-arithmetic model of the PE.
module tb_pe_ws;
    import pe_ws_pkg::*;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 16;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic [DW-1:0] t_left = '0;
    logic          t_lv   = 1'b0;
    logic [AW-1:0] t_top  = '0;
    logic          t_tv   = 1'b0;
    logic [DW-1:0] t_wd   = '0;
    logic          t_wl   = 1'b0;
    logic          t_sw   = 1'b0;
    pe_mode_t      t_mode = PASSTHROUGH;
    logic          t_az   = 1'b0;
    logic          t_clr  = 1'b0;

    pe_ws_if #(.DATA_W(DW), .ACC_W(AW)) bus_s ();
    pe_ws_if #(.DATA_W(DW), .ACC_W(AW)) bus_w ();

    assign bus_s.left_data_i  = t_left;  assign bus_w.left_data_i  = t_left;
    assign bus_s.left_valid_i = t_lv;    assign bus_w.left_valid_i = t_lv;
    assign bus_s.top_psum_i   = t_top;   assign bus_w.top_psum_i   = t_top;
    assign bus_s.top_valid_i  = t_tv;    assign bus_w.top_valid_i  = t_tv;
    assign bus_s.w_data_i     = t_wd;    assign bus_w.w_data_i     = t_wd;
    assign bus_s.w_load_i     = t_wl;    assign bus_w.w_load_i     = t_wl;
    assign bus_s.swap_i       = t_sw;    assign bus_w.swap_i       = t_sw;
    assign bus_s.mode_i       = t_mode;  assign bus_w.mode_i       = t_mode;
    assign bus_s.add_zero_i   = t_az;    assign bus_w.add_zero_i   = t_az;
    assign bus_s.clr_flags_i  = t_clr;   assign bus_w.clr_flags_i  = t_clr;

    pe_ws #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1'b1), .SATURATE(1'b1)) dut_sat (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus_s)
    );

    pe_ws #(.DATA_W(DW), .ACC_W(AW), .SIGNED(1'b1), .SATURATE(1'b0)) dut_wrap (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus_w)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state, held as signed integers
    byte     m_shadow, m_active, m_wdo, m_rd;
    bit      m_rv, m_wlo, m_swo, m_bv;
    shortint m_bp_s, m_bp_w;
    bit      m_ovf_s, m_ovf_w, m_err;

    task automatic model_reset();
        m_shadow = 0; m_active = 0; m_wdo = 0; m_rd = 0;
        m_rv = 0; m_wlo = 0; m_swo = 0; m_bv = 0;
        m_bp_s = 0; m_bp_w = 0;
        m_ovf_s = 0; m_ovf_w = 0; m_err = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rd"},   32'(bus_s.right_data_o),   32'($unsigned(m_rd)));
        chk({tag, ".rv"},   32'(bus_s.right_valid_o),  32'(m_rv));
        chk({tag, ".wdo"},  32'(bus_s.w_data_o),       32'($unsigned(m_wdo)));
        chk({tag, ".wlo"},  32'(bus_s.w_load_o),       32'(m_wlo));
        chk({tag, ".swo"},  32'(bus_s.swap_o),         32'(m_swo));
        chk({tag, ".bp_s"}, 32'(bus_s.bottom_psum_o),  32'($unsigned(m_bp_s)));
        chk({tag, ".bv_s"}, 32'(bus_s.bottom_valid_o), 32'(m_bv));
        chk({tag, ".ovf_s"},32'(bus_s.ovf_o),          32'(m_ovf_s));
        chk({tag, ".err_s"},32'(bus_s.err_o),          32'(m_err));
        chk({tag, ".bp_w"}, 32'(bus_w.bottom_psum_o),  32'($unsigned(m_bp_w)));
        chk({tag, ".bv_w"}, 32'(bus_w.bottom_valid_o), 32'(m_bv));
        chk({tag, ".ovf_w"},32'(bus_w.ovf_o),          32'(m_ovf_w));
        chk({tag, ".err_w"},32'(bus_w.err_o),          32'(m_err));
    endtask

    // One clock: predict from current inputs, advance, compare
    task automatic step(input string tag);
        int prod, acc, sum, sat;
        byte n_shadow, n_active, n_wdo;
        bit ovf_s_set, ovf_w_set, err_set;
        prod = int'(m_active) * int'($signed(t_left));
        acc  = t_az ? 0 : int'($signed(t_top));
        sum  = acc + prod;
        sat  = (sum > 32767) ? 32767 : ((sum < -32768) ? -32768 : sum);
        ovf_s_set = 0; ovf_w_set = 0; err_set = 0;
        n_shadow = t_wl ? byte'(t_wd) : m_shadow;
        n_wdo    = t_wl ? m_shadow : m_wdo;
        n_active = t_sw ? m_shadow : m_active;
        @(posedge clk_i);
        #1;
        if (t_mode == PASSTHROUGH) begin
            m_bp_s = shortint'(t_top);
            m_bp_w = shortint'(t_top);
            m_bv   = t_tv;
        end else if (t_lv) begin
            m_bp_s = shortint'(sat);
            m_bp_w = shortint'(sum);
            m_bv   = 1;
            ovf_s_set = (sat != sum);
            ovf_w_set = (sat != sum);
            err_set   = !t_az && !t_tv;
        end else begin
            m_bv = 0;
        end
        m_ovf_s = t_clr ? 1'b0 : (m_ovf_s | ovf_s_set);
        m_ovf_w = t_clr ? 1'b0 : (m_ovf_w | ovf_w_set);
        m_err   = t_clr ? 1'b0 : (m_err | err_set);
        m_shadow = n_shadow; m_active = n_active; m_wdo = n_wdo;
        m_rd = byte'(t_left); m_rv = t_lv; m_wlo = t_wl; m_swo = t_sw;
        check_all(tag);
    endtask

    task automatic idle();
        t_left = '0; t_lv = 0; t_top = '0; t_tv = 0; t_wd = '0;
        t_wl = 0; t_sw = 0; t_mode = PASSTHROUGH; t_az = 0; t_clr = 0;
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk_i);
        #3;
        t_wl = 1; t_wd = 8'h55; t_mode = PROCESS; t_lv = 1; t_left = 8'h11;
        rst_ni = 0;
        #1;
        model_reset();
        check_all({tag, ".imm"});
        @(posedge clk_i);
        #1;
        check_all({tag, ".held"});
        @(negedge clk_i);
        rst_ni = 1;
        idle();
    endtask

    initial begin
        model_reset();
        idle();
        #1;
        check_all("rst");
        #11;
        rst_ni = 1;

        // Shift chain 5 then 9, then swap
        t_wl = 1; t_wd = 8'd5; step("ld5");
        t_wd = 8'd9; step("ld9");
        chk("chain_wdo5", 32'(bus_s.w_data_o), 32'd5);
        t_wl = 0; t_sw = 1; step("swap9");
        chk("swap_o", 32'(bus_s.swap_o), 32'd1);
        // Compute with weight 9 while shifting -3 in (exposes shadow=9)
        t_sw = 0; t_mode = PROCESS; t_lv = 1; t_left = 8'd1; t_az = 1;
        t_wl = 1; t_wd = 8'hFD; step("use9");
        chk("act9", 32'(bus_s.bottom_psum_o), 32'd9);
        chk("shadow9", 32'(bus_s.w_data_o), 32'd9);
        idle(); t_sw = 1; step("swapm3");

        // MAC: -3*7 + 100
        idle(); t_mode = PROCESS; t_lv = 1; t_left = 8'd7; t_top = 16'd100; t_tv = 1;
        step("mac");
        chk("mac79", 32'(bus_s.bottom_psum_o), 32'd79);
        chk("mac_valid", 32'(bus_s.bottom_valid_o), 32'd1);

        // Saturation / wrap
        idle(); t_wl = 1; t_wd = 8'd127; step("ld127");
        idle(); t_sw = 1; step("swap127");
        idle(); t_mode = PROCESS; t_lv = 1; t_left = 8'd127; t_top = 16'd32767; t_tv = 1;
        step("sat");
        chk("sat_max", 32'(bus_s.bottom_psum_o), 32'(16'h7FFF));
        chk("sat_ovf", 32'(bus_s.ovf_o), 32'd1);
        chk("wrap_val", 32'(bus_w.bottom_psum_o), 32'(16'hBF00));
        chk("wrap_ovf", 32'(bus_w.ovf_o), 32'd1);
        idle(); t_clr = 1; step("clr");
        chk("ovf_clr", 32'(bus_s.ovf_o), 32'd0);
        // Clear wins over a same-cycle overflow
        idle(); t_mode = PROCESS; t_lv = 1; t_left = 8'd127; t_top = 16'd32767; t_tv = 1; t_clr = 1;
        step("clr_prio");

        // Same-cycle load and swap: shadow 4 -> active, 6 -> shadow; compute uses 127
        idle(); t_wl = 1; t_wd = 8'd4; step("ld4");
        idle(); t_wl = 1; t_wd = 8'd6; t_sw = 1; t_mode = PROCESS; t_lv = 1; t_left = 8'd2; t_az = 1;
        step("ldswap");
        chk("old_active", 32'(bus_s.bottom_psum_o), 32'd254);
        idle(); t_mode = PROCESS; t_lv = 1; t_left = 8'd1; t_az = 1; t_wl = 1; t_wd = 8'd0;
        step("new_active");
        chk("active4", 32'(bus_s.bottom_psum_o), 32'd4);
        chk("shadow6", 32'(bus_s.w_data_o), 32'd6);

        // Protocol error, then passthrough; PROCESS without valid holds psum
        idle(); t_mode = PROCESS; t_lv = 1; t_left = 8'd1; t_top = 16'd10; t_tv = 0;
        step("proto");
        chk("err_set", 32'(bus_s.err_o), 32'd1);
        idle(); t_mode = PROCESS; t_top = 16'd999; t_tv = 1; step("hold");
        idle(); t_top = 16'd1234; t_tv = 1; step("pass");
        chk("pass1234", 32'(bus_s.bottom_psum_o), 32'd1234);
        chk("err_sticky", 32'(bus_s.err_o), 32'd1);
        idle(); t_clr = 1; step("clr2");

        async_reset("arst");
        chk("arst_err", 32'(bus_s.err_o), 32'd0);

        // Random traffic with a reset in the middle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset("arst2");
            t_left = 8'($urandom);
            t_lv   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: t_top = 16'h7FFF;
                1: t_top = 16'h8000;
                default: t_top = 16'($urandom);
            endcase
            t_tv   = ($urandom_range(0, 7) != 0);
            t_wd   = 8'($urandom);
            t_wl   = ($urandom_range(0, 2) == 0);
            t_sw   = ($urandom_range(0, 4) == 0);
            t_mode = ($urandom_range(0, 3) == 0) ? PASSTHROUGH : PROCESS;
            t_az   = ($urandom_range(0, 3) == 0);
            t_clr  = ($urandom_range(0, 15) == 0);
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_pe_ws
